// File: rtl/coverfloat_flag_accum_pkg.sv
// Shared flag encoding for the coverfloat exception-flag accumulator.
package coverfloat_flag_accum_pkg;

  localparam int unsigned FLAG_W = 5;

  // SoftFloat exception flag masks
  localparam logic [FLAG_W-1:0] FLAG_INEXACT_MASK   = 5'h01;
  localparam logic [FLAG_W-1:0] FLAG_UNDERFLOW_MASK = 5'h02;
  localparam logic [FLAG_W-1:0] FLAG_OVERFLOW_MASK  = 5'h04;
  localparam logic [FLAG_W-1:0] FLAG_INFINITE_MASK  = 5'h08;
  localparam logic [FLAG_W-1:0] FLAG_INVALID_MASK   = 5'h10;

  // Bit positions recovered from the one-hot masks
  localparam int unsigned FLAG_BIT_INEXACT   = $clog2(FLAG_INEXACT_MASK);
  localparam int unsigned FLAG_BIT_UNDERFLOW = $clog2(FLAG_UNDERFLOW_MASK);
  localparam int unsigned FLAG_BIT_OVERFLOW  = $clog2(FLAG_OVERFLOW_MASK);
  localparam int unsigned FLAG_BIT_INFINITE  = $clog2(FLAG_INFINITE_MASK);
  localparam int unsigned FLAG_BIT_INVALID   = $clog2(FLAG_INVALID_MASK);

  typedef logic [FLAG_W-1:0] flag_vec_t;

endpackage

// File: rtl/coverfloat_sat_counter.sv
// Saturating up-counter with synchronous clear; clear-then-increment in one cycle.
module coverfloat_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] r_q;

  assign q = r_q;

  // An increment arrives while the counter already sits at full scale
  assign sat_hit = inc && !clr && (r_q == MAX_VAL);

  // Count register: clear wins over hold, increment applied after clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= inc ? W'(1) : '0;
    end else if (inc && (r_q != MAX_VAL)) begin
      r_q <= r_q + W'(1);
    end
  end

endmodule

// File: rtl/coverfloat_flag_accum.sv
// Multi-channel sticky/counting accumulator of SoftFloat exception flags with a registered read port.
module coverfloat_flag_accum
  import coverfloat_flag_accum_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned NUM_FLAGS = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_CH-1:0]                           in_valid,
  input  logic [NUM_CH*NUM_FLAGS-1:0]                 in_flags,
  input  logic                                        rd_req,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  input  logic                                        rd_clear,
  output logic                                        rd_valid,
  output logic                                        rd_err,
  output logic [NUM_FLAGS-1:0]                        rd_sticky,
  output logic [NUM_FLAGS*CNT_W-1:0]                  rd_counts,
  output logic [CNT_W-1:0]                            rd_total,
  output logic                                        rd_sat,
  output logic                                        any_invalid
);

  logic [NUM_FLAGS-1:0]       w_sticky_q [NUM_CH];
  logic [CNT_W-1:0]           w_cnt      [NUM_CH][NUM_FLAGS];
  logic [CNT_W-1:0]           w_tot      [NUM_CH];
  logic [NUM_CH-1:0]          w_sat_q;
  logic [NUM_CH-1:0]          w_clr;
  logic [NUM_CH-1:0]          w_inv_nxt;

  logic                       w_rd_hit;
  logic [NUM_FLAGS-1:0]       w_rd_sticky;
  logic [NUM_FLAGS*CNT_W-1:0] w_rd_counts;
  logic [CNT_W-1:0]           w_rd_total;
  logic                       w_rd_sat;

  logic                       r_rd_valid;
  logic                       r_rd_err;
  logic [NUM_FLAGS-1:0]       r_rd_sticky;
  logic [NUM_FLAGS*CNT_W-1:0] r_rd_counts;
  logic [CNT_W-1:0]           r_rd_total;
  logic                       r_rd_sat;
  logic                       r_any_invalid;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_FLAGS-1:0] w_flags;
    logic [NUM_FLAGS:0]   w_hit;
    logic [NUM_FLAGS-1:0] w_sticky_nxt;
    logic                 w_sat_nxt;
    logic [NUM_FLAGS-1:0] r_sticky;
    logic                 r_sat;

    assign w_flags  = in_flags[c*NUM_FLAGS +: NUM_FLAGS];
    assign w_clr[c] = rd_req && rd_clear && (32'(rd_ch) == 32'(c));

    for (genvar f = 0; f < NUM_FLAGS; f++) begin : g_flag
      coverfloat_sat_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr[c]),
        .inc     (in_valid[c] && w_flags[f]),
        .q       (w_cnt[c][f]),
        .sat_hit (w_hit[f])
      );
    end

    coverfloat_sat_counter #(.W(CNT_W)) u_total (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_clr[c]),
      .inc     (in_valid[c]),
      .q       (w_tot[c]),
      .sat_hit (w_hit[NUM_FLAGS])
    );

    // Next sticky/sat state: clear first, then fold in this cycle's event
    always_comb begin
      w_sticky_nxt = w_clr[c] ? '0 : r_sticky;
      if (in_valid[c]) begin
        w_sticky_nxt = w_sticky_nxt | w_flags;
      end
      w_sat_nxt = !w_clr[c] && (r_sat || (|w_hit));
    end

    // Per-channel sticky flags and saturation marker
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sticky <= '0;
        r_sat    <= 1'b0;
      end else begin
        r_sticky <= w_sticky_nxt;
        r_sat    <= w_sat_nxt;
      end
    end

    assign w_sticky_q[c] = r_sticky;
    assign w_sat_q[c]    = r_sat;

    if (NUM_FLAGS > FLAG_BIT_INVALID) begin : g_inv
      assign w_inv_nxt[c] = w_sticky_nxt[FLAG_BIT_INVALID];
    end else begin : g_no_inv
      assign w_inv_nxt[c] = 1'b0;
    end
  end

  // Select the requested channel's pre-update state; out-of-range yields zeros
  always_comb begin
    w_rd_hit    = 1'b0;
    w_rd_sticky = '0;
    w_rd_counts = '0;
    w_rd_total  = '0;
    w_rd_sat    = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(rd_ch) == c) begin
        w_rd_hit    = 1'b1;
        w_rd_sticky = w_sticky_q[c];
        for (int unsigned f = 0; f < NUM_FLAGS; f++) begin
          w_rd_counts[f*CNT_W +: CNT_W] = w_cnt[c][f];
        end
        w_rd_total  = w_tot[c];
        w_rd_sat    = w_sat_q[c];
      end
    end
  end

  // Read response register; data holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid    <= 1'b0;
      r_rd_err      <= 1'b0;
      r_rd_sticky   <= '0;
      r_rd_counts   <= '0;
      r_rd_total    <= '0;
      r_rd_sat      <= 1'b0;
      r_any_invalid <= 1'b0;
    end else begin
      r_rd_valid    <= rd_req;
      r_rd_err      <= rd_req && !w_rd_hit;
      if (rd_req) begin
        r_rd_sticky <= w_rd_sticky;
        r_rd_counts <= w_rd_counts;
        r_rd_total  <= w_rd_total;
        r_rd_sat    <= w_rd_sat;
      end
      r_any_invalid <= |w_inv_nxt;
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;
  assign rd_sticky   = r_rd_sticky;
  assign rd_counts   = r_rd_counts;
  assign rd_total    = r_rd_total;
  assign rd_sat      = r_rd_sat;
  assign any_invalid = r_any_invalid;

endmodule

// File: tb/tb_coverfloat_flag_accum.sv
// Bench for coverfloat_flag_accum: directed vector table plus randomized run against a reference model.
module tb_coverfloat_flag_accum;
  import coverfloat_flag_accum_pkg::*;

  localparam int NCH  = 5;
  localparam int NF   = 5;
  localparam int CW   = 3;
  localparam int MAXC = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       in_valid;
  logic [NCH*NF-1:0]    in_flags;
  logic                 rd_req;
  logic [2:0]           rd_ch;
  logic                 rd_clear;
  logic                 rd_valid;
  logic                 rd_err;
  logic [NF-1:0]        rd_sticky;
  logic [NF*CW-1:0]     rd_counts;
  logic [CW-1:0]        rd_total;
  logic                 rd_sat;
  logic                 any_invalid;

  coverfloat_flag_accum #(.NUM_CH(NCH), .NUM_FLAGS(NF), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_flags    (in_flags),
    .rd_req      (rd_req),
    .rd_ch       (rd_ch),
    .rd_clear    (rd_clear),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .rd_sticky   (rd_sticky),
    .rd_counts   (rd_counts),
    .rd_total    (rd_total),
    .rd_sat      (rd_sat),
    .any_invalid (any_invalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  flag_vec_t m_sticky [NCH];
  int        m_cnt    [NCH][NF];
  int        m_tot    [NCH];
  bit        m_sat    [NCH];

  // Expected output register contents
  bit            x_valid, x_err, x_sat, x_inv;
  logic [NF-1:0] x_sticky;
  logic [NF*CW-1:0] x_counts;
  logic [CW-1:0] x_total;

  typedef struct {
    bit               r;
    logic [NCH-1:0]   v;
    logic [NCH*NF-1:0] fl;
    bit               q;
    logic [2:0]       ch;
    bit               cl;
    bit               e_valid;
    bit               e_err;
    logic [NF-1:0]    e_sticky;
    logic [NF*CW-1:0] e_counts;
    logic [CW-1:0]    e_total;
    bit               e_sat;
    bit               e_inv;
  } vec_t;

  vec_t tbl[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [NF*CW-1:0] cnt(input int a, input int b, input int c, input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic [NCH*NF-1:0] fv(input int c, input logic [4:0] f);
    logic [NCH*NF-1:0] t;
    t = '0;
    t[c*NF +: NF] = f;
    return t;
  endfunction

  function automatic logic [NCH-1:0] vb(input int c);
    return NCH'(1) << c;
  endfunction

  function automatic void bump(inout int val, inout bit sat);
    if (val == MAXC) sat = 1'b1;
    else val++;
  endfunction

  function automatic vec_t mk(input bit r, input logic [NCH-1:0] v, input logic [NCH*NF-1:0] fl,
                              input bit q, input int ch, input bit cl,
                              input bit ev, input bit ee, input logic [NF-1:0] es,
                              input logic [NF*CW-1:0] ec, input int et, input bit esat, input bit einv);
    vec_t t;
    t.r = r; t.v = v; t.fl = fl; t.q = q; t.ch = 3'(ch); t.cl = cl;
    t.e_valid = ev; t.e_err = ee; t.e_sticky = es; t.e_counts = ec;
    t.e_total = 3'(et); t.e_sat = esat; t.e_inv = einv;
    return t;
  endfunction

  // Drive one cycle, advance the model, compare every output after the edge
  task automatic run_cycle(input bit r, input logic [NCH-1:0] v, input logic [NCH*NF-1:0] fl,
                           input bit q, input logic [2:0] ch, input bit cl);
    rst = r; in_valid = v; in_flags = fl; rd_req = q; rd_ch = ch; rd_clear = cl;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_sticky[c] = '0; m_tot[c] = 0; m_sat[c] = 1'b0;
        for (int f = 0; f < NF; f++) m_cnt[c][f] = 0;
      end
      x_valid = 0; x_err = 0; x_sticky = '0; x_counts = '0; x_total = '0; x_sat = 0; x_inv = 0;
    end else begin
      x_valid = q;
      x_err   = q && (int'(ch) >= NCH);
      if (q) begin
        if (int'(ch) >= NCH) begin
          x_sticky = '0; x_counts = '0; x_total = '0; x_sat = 0;
        end else begin
          x_sticky = m_sticky[ch];
          for (int f = 0; f < NF; f++) x_counts[f*CW +: CW] = 3'(m_cnt[ch][f]);
          x_total = 3'(m_tot[ch]);
          x_sat   = m_sat[ch];
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (q && cl && int'(ch) == c) begin
          m_sticky[c] = '0; m_tot[c] = 0; m_sat[c] = 1'b0;
          for (int f = 0; f < NF; f++) m_cnt[c][f] = 0;
        end
        if (v[c]) begin
          m_sticky[c] |= fl[c*NF +: NF];
          bump(m_tot[c], m_sat[c]);
          for (int f = 0; f < NF; f++)
            if (fl[c*NF + f]) bump(m_cnt[c][f], m_sat[c]);
        end
      end
      x_inv = 0;
      for (int c = 0; c < NCH; c++) x_inv |= m_sticky[c][FLAG_BIT_INVALID];
    end
    @(posedge clk);
    #1;
    check("model_rd_valid",    32'(rd_valid),    32'(x_valid));
    check("model_rd_err",      32'(rd_err),      32'(x_err));
    check("model_rd_sticky",   32'(rd_sticky),   32'(x_sticky));
    check("model_rd_counts",   32'(rd_counts),   32'(x_counts));
    check("model_rd_total",    32'(rd_total),    32'(x_total));
    check("model_rd_sat",      32'(rd_sat),      32'(x_sat));
    check("model_any_invalid", 32'(any_invalid), 32'(x_inv));
  endtask

  initial begin
    logic [NCH*NF-1:0] all_fl;
    all_fl = '1;
    rst = 1'b1; in_valid = '0; in_flags = '0; rd_req = 1'b0; rd_ch = '0; rd_clear = 1'b0;

    // reset, read empty ch0
    tbl.push_back(mk(1, '0, '0, 0, 0, 0,  0, 0, 5'b00000, '0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 1, 0, 0,  1, 0, 5'b00000, '0, 0, 0, 0));
    // ch1: inexact x3 then invalid+overflow
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, vb(1), fv(1, 5'b00001), 0, 0, 0,  0, 0, 5'b00000, '0, 0, 0, 0));
    tbl.push_back(mk(0, vb(1), fv(1, 5'b10100), 0, 0, 0,  0, 0, 5'b00000, '0, 0, 0, 1));
    tbl.push_back(mk(0, '0, '0, 1, 1, 0,  1, 0, 5'b10101, cnt(3,0,1,0,1), 4, 0, 1));
    for (int c = 0; c < NCH; c++)
      if (c != 1) tbl.push_back(mk(0, '0, '0, 1, c, 0,  1, 0, 5'b00000, '0, 0, 0, 1));
    // ch0 saturation: 9 ops against a 3-bit counter
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(0, vb(0), fv(0, 5'b00001), 0, 0, 0,  0, 0, 5'b00000, '0, 0, 0, 1));
    tbl.push_back(mk(0, '0, '0, 1, 0, 0,  1, 0, 5'b00001, cnt(7,0,0,0,0), 7, 1, 1));
    tbl.push_back(mk(0, '0, '0, 1, 0, 1,  1, 0, 5'b00001, cnt(7,0,0,0,0), 7, 1, 1));
    tbl.push_back(mk(0, '0, '0, 1, 0, 0,  1, 0, 5'b00000, '0, 0, 0, 1));
    // ch2: total=7, then clear together with an underflow update
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, vb(2), '0, 0, 0, 0,  0, 0, 5'b00000, '0, 0, 0, 1));
    tbl.push_back(mk(0, vb(2), fv(2, 5'b00010), 1, 2, 1,  1, 0, 5'b00000, '0, 7, 0, 1));
    tbl.push_back(mk(0, '0, '0, 1, 2, 0,  1, 0, 5'b00010, cnt(0,1,0,0,0), 1, 0, 1));
    // out-of-range clears leave state alone
    tbl.push_back(mk(0, '0, '0, 1, 5, 1,  1, 1, 5'b00000, '0, 0, 0, 1));
    tbl.push_back(mk(0, '0, '0, 1, 7, 1,  1, 1, 5'b00000, '0, 0, 0, 1));
    tbl.push_back(mk(0, '0, '0, 1, 1, 0,  1, 0, 5'b10101, cnt(3,0,1,0,1), 4, 0, 1));
    tbl.push_back(mk(0, '0, '0, 0, 1, 1,  0, 0, 5'b10101, cnt(3,0,1,0,1), 4, 0, 1));
    // invalid pending on ch1 and ch3, cleared one at a time
    tbl.push_back(mk(0, vb(3), fv(3, 5'b10000), 0, 0, 0,  0, 0, 5'b10101, cnt(3,0,1,0,1), 4, 0, 1));
    tbl.push_back(mk(0, '0, '0, 1, 1, 1,  1, 0, 5'b10101, cnt(3,0,1,0,1), 4, 0, 1));
    tbl.push_back(mk(0, '0, '0, 1, 3, 1,  1, 0, 5'b10000, cnt(0,0,0,0,1), 1, 0, 0));
    // reset mid-stream with every channel active
    tbl.push_back(mk(0, '1, all_fl, 0, 0, 0,  0, 0, 5'b10000, cnt(0,0,0,0,1), 1, 0, 1));
    tbl.push_back(mk(1, '1, all_fl, 0, 0, 0,  0, 0, 5'b00000, '0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 1, 4, 0,  1, 0, 5'b00000, '0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 1, 1, 0,  1, 0, 5'b00000, '0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i].r, tbl[i].v, tbl[i].fl, tbl[i].q, tbl[i].ch, tbl[i].cl);
      check($sformatf("vec%0d_rd_valid", i),    32'(rd_valid),    32'(tbl[i].e_valid));
      check($sformatf("vec%0d_rd_err", i),      32'(rd_err),      32'(tbl[i].e_err));
      check($sformatf("vec%0d_rd_sticky", i),   32'(rd_sticky),   32'(tbl[i].e_sticky));
      check($sformatf("vec%0d_rd_counts", i),   32'(rd_counts),   32'(tbl[i].e_counts));
      check($sformatf("vec%0d_rd_total", i),    32'(rd_total),    32'(tbl[i].e_total));
      check($sformatf("vec%0d_rd_sat", i),      32'(rd_sat),      32'(tbl[i].e_sat));
      check($sformatf("vec%0d_any_invalid", i), 32'(any_invalid), 32'(tbl[i].e_inv));
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [NCH-1:0]    v;
      logic [NCH*NF-1:0] fl;
      v  = NCH'($urandom);
      fl = (NCH*NF)'($urandom) & (NCH*NF)'($urandom);
      run_cycle($urandom_range(0, 99) == 0, v, fl,
                $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
